// File: rtl/ds_rr_arbiter.sv
// ds_rr_arbiter: N-to-1 round-robin arbiter and mux for DataStream sources.
//
// One downstream sink (typically the write side of a DataStream FIFO) is
// shared between N requesters. A grant is held for a burst of up to MAXBURST
// words, or until the granted source drops i_val, then passes to the next
// requester in round-robin order. Each new grant costs one bubble cycle.
//
// Parameters:
//   DWIDTH    stream width
//   N         number of inbound streams (>= 1)
//   MAXBURST  maximum words per grant; 0 means unlimited
//
// Ports:
//   reset  synchronous, active-high reset
//   clk    clock
//   i_dat  inbound data, stream k is bits [k*DWIDTH +: DWIDTH]
//   i_val  inbound valid, one per stream
//   i_rdy  inbound ready, one per stream (only the granted stream can be ready)
//   o_dat  outbound data
//   o_val  outbound valid
//   o_rdy  outbound ready
//   o_sel  index of the granted stream (0 while idle)
//
// Optional feature: define DS_RR_ARBITER_OREG_EN to insert a 2-entry skid
// slice between the mux and o_dat/o_val. This breaks the o_rdy -> i_rdy
// combinational path at the cost of one cycle of latency, with full
// throughput. Without the macro the output path is purely combinational.
module ds_rr_arbiter #(
  parameter int DWIDTH   = 8,
  parameter int N        = 4,
  parameter int MAXBURST = 16,
  localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                reset,
  input  logic                clk,
  input  logic [N*DWIDTH-1:0] i_dat,
  input  logic [N-1:0]        i_val,
  output logic [N-1:0]        i_rdy,
  output logic [DWIDTH-1:0]   o_dat,
  output logic                o_val,
  input  logic                o_rdy,
  output logic [SW-1:0]       o_sel
);

  localparam int CW = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Last burst index; only meaningful when MAXBURST is non-zero.
  localparam logic [CW-1:0] CNT_LAST = CW'((MAXBURST > 0) ? MAXBURST - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] SEL_ONE  = SW'(1);
  localparam logic [SW-1:0] SEL_MAX  = SW'(N - 1);

  logic [0:0]        state_r;
  logic [SW-1:0]     sel_r;
  logic [SW-1:0]     ptr_r;
  logic [CW-1:0]     cnt_r;

  logic [DWIDTH-1:0] dat_arr_s [N];
  logic [SW-1:0]     pick_s;
  logic [SW-1:0]     cand_s;
  logic              found_s;
  logic [SW-1:0]     sel_inc_s;
  logic              grant_s;
  logic              mux_val_s;
  logic [DWIDTH-1:0] mux_dat_s;
  logic              core_rdy_s;
  logic              xfer_s;
  logic              release_s;

  genvar g;
  for (g = 0; g < N; g++) begin : g_unpack
    assign dat_arr_s[g] = i_dat[g*DWIDTH +: DWIDTH];
  end

  assign grant_s   = (state_r == ST_GRANT);
  assign mux_val_s = grant_s & i_val[sel_r];
  assign mux_dat_s = dat_arr_s[sel_r];
  assign xfer_s    = mux_val_s & core_rdy_s;
  assign sel_inc_s = (sel_r == SEL_MAX) ? '0 : sel_r + SEL_ONE;
  assign o_sel     = grant_s ? sel_r : '0;

  // Release on a dropped valid, or on the transfer that completes a burst.
  assign release_s = grant_s &
                     (~i_val[sel_r] |
                      (xfer_s & (MAXBURST != 0) & (cnt_r == CNT_LAST)));

  // Round-robin pick: first requesting stream at or after ptr, modulo N.
  always_comb begin
    pick_s  = ptr_r;
    cand_s  = ptr_r;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s = SW'((int'(ptr_r) + i) % N);
      if (!found_s && i_val[cand_s]) begin
        pick_s  = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Only the granted stream sees the (internal) downstream ready.
  always_comb begin
    i_rdy = '0;
    if (grant_s) begin
      i_rdy[sel_r] = core_rdy_s;
    end else begin
      i_rdy = '0;
    end
  end

  // Grant FSM: arbitration in IDLE, burst counting and release in GRANT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sel_r   <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|i_val) begin
            sel_r   <= pick_s;
            cnt_r   <= '0;
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            state_r <= ST_IDLE;
            ptr_r   <= sel_inc_s;
          end else if (xfer_s && (MAXBURST != 0)) begin
            // Unlimited bursts leave cnt parked at zero so it never wraps.
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DS_RR_ARBITER_OREG_EN
  // Two-entry skid slice; entry 0 is always the head presented on o_dat.
  logic [DWIDTH-1:0] sk0_r;
  logic [DWIDTH-1:0] sk1_r;
  logic [1:0]        sk_cnt_r;
  logic              sk_pop_s;

  assign core_rdy_s = (sk_cnt_r != 2'd2);
  assign sk_pop_s   = (sk_cnt_r != 2'd0) & o_rdy;
  assign o_val      = (sk_cnt_r != 2'd0);
  assign o_dat      = sk0_r;

  // Slice storage: push from the mux, pop toward the sink.
  always_ff @(posedge clk) begin
    if (reset) begin
      sk0_r    <= '0;
      sk1_r    <= '0;
      sk_cnt_r <= 2'd0;
    end else begin
      case ({xfer_s, sk_pop_s})
        2'b10: begin
          if (sk_cnt_r == 2'd0) begin
            sk0_r <= mux_dat_s;
          end else begin
            sk1_r <= mux_dat_s;
          end
          sk_cnt_r <= sk_cnt_r + 2'd1;
        end
        2'b01: begin
          sk0_r    <= sk1_r;
          sk_cnt_r <= sk_cnt_r - 2'd1;
        end
        2'b11: begin
          if (sk_cnt_r == 2'd1) begin
            sk0_r <= mux_dat_s;
          end else begin
            sk0_r <= sk1_r;
            sk1_r <= mux_dat_s;
          end
        end
        default: begin
          sk_cnt_r <= sk_cnt_r;
        end
      endcase
    end
  end
`else
  assign core_rdy_s = o_rdy;
  assign o_val      = mux_val_s;
  assign o_dat      = mux_dat_s;
`endif

endmodule

// File: tb/tb_ds_rr_arbiter.sv
// Testbench for ds_rr_arbiter: randomized and directed DataStream traffic,
// scoreboard of expected output words computed from round-robin burst rules.
`timescale 1ns/1ps
module tb_ds_rr_arbiter;

  localparam int DW     = 8;
  localparam int N      = 4;
  localparam int MB     = 4;
  localparam int BUDGET = 300;
`ifdef DS_RR_ARBITER_OREG_EN
  localparam int LAT    = 1;
  localparam int N_PRE  = 2;
`else
  localparam int LAT    = 0;
  localparam int N_PRE  = 3;
`endif

  logic            clk;
  logic            reset;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_val;
  logic [N-1:0]    i_rdy;
  logic [DW-1:0]   o_dat;
  logic            o_val;
  logic            o_rdy;
  logic [1:0]      o_sel;

  logic            z_reset;
  logic [2*DW-1:0] z_i_dat;
  logic [1:0]      z_i_val;
  logic [1:0]      z_i_rdy;
  logic [DW-1:0]   z_o_dat;
  logic            z_o_val;
  logic            z_o_rdy;
  logic [0:0]      z_o_sel;

  ds_rr_arbiter #(.DWIDTH(DW), .N(N), .MAXBURST(MB)) u_dut (
    .reset(reset), .clk(clk), .i_dat(i_dat), .i_val(i_val), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_rdy(o_rdy), .o_sel(o_sel)
  );

  ds_rr_arbiter #(.DWIDTH(DW), .N(2), .MAXBURST(0)) u_dut_unl (
    .reset(z_reset), .clk(clk), .i_dat(z_i_dat), .i_val(z_i_val), .i_rdy(z_i_rdy),
    .o_dat(z_o_dat), .o_val(z_o_val), .o_rdy(z_o_rdy), .o_sel(z_o_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         sel;
    int         cyc;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] src [N][$];
  int         seq [N];
  int         model_ptr = 0;
  int         cyc = 0;
  bit         reset_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue n words on stream k; each word carries its stream id and sequence.
  task automatic load(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      src[k].push_back({k[1:0], 6'(seq[k])});
      seq[k]++;
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int k = 0; k < N; k++) if (src[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Reference model: sources keep i_val high while they hold words, so the
  // output order is fixed by round-robin over queues with bursts of at most
  // MB words. With o_rdy held high the cycle of each transfer is also known:
  // one arbitration bubble per grant, plus one release cycle when a source
  // runs dry before filling its burst.
  task automatic build_expected(input bit timed);
    logic [7:0] cp [N][$];
    int   t, k, w, c;
    exp_t e;
    for (int i = 0; i < N; i++) cp[i] = src[i];
    t = 0;
    forever begin
      k = -1;
      for (int i = 0; i < N; i++) begin
        c = (model_ptr + i) % N;
        if (k < 0 && cp[c].size() > 0) k = c;
      end
      if (k < 0) break;
      t++;
      w = (cp[k].size() < MB) ? cp[k].size() : MB;
      for (int j = 0; j < w; j++) begin
        e.dat = cp[k].pop_front();
        e.sel = k;
        e.cyc = timed ? t + LAT : -1;
        sb.push_back(e);
        t++;
      end
      if (w < MB) t++;
      model_ptr = (k + 1) % N;
    end
  endtask

  // One clock of source/sink behaviour; handshakes sampled just before posedge.
  task automatic drive_cycle(input int c, input logic rdy, input logic rst);
    @(negedge clk);
    cyc   = c;
    reset = rst;
    o_rdy = rdy;
    for (int k = 0; k < N; k++) begin
      i_val[k] = (src[k].size() > 0);
      if (src[k].size() > 0) i_dat[k*DW +: DW] = src[k][0];
      else                   i_dat[k*DW +: DW] = 8'h00;
    end
    #4;
    for (int k = 0; k < N; k++) begin
      if (i_val[k] && i_rdy[k]) void'(src[k].pop_front());
    end
  endtask

  // mode 0: o_rdy always high (timing checked); 1: random o_rdy; 2: stall 3..7.
  task automatic run_phase(input string name, input int mode);
    int   idle = 0;
    bit   done = 1'b0;
    logic r;
    build_expected(mode == 0);
    for (int c = 0; c < BUDGET && !done; c++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = !(c >= 3 && c <= 7);
      endcase
      drive_cycle(c, r, 1'b0);
      if (reset_chk && c == 0) begin
        check("post_reset_o_val", o_val, 0);
        check("post_reset_i_rdy", i_rdy, 0);
        check("post_reset_o_sel", o_sel, 0);
      end
      if (mode == 2 && c == 7) begin
        check("stall_i_rdy", i_rdy, 0);
        check("stall_o_val", o_val, 1);
        check("stall_o_sel", o_sel, 1);
      end
      if (all_empty() && sb.size() == 0) idle++;
      else idle = 0;
      if (idle >= 3) done = 1'b1;
    end
    check({name, "_completed"}, done, 1);
    if (!done) begin
      sb.delete();
      for (int k = 0; k < N; k++) src[k].delete();
    end
  endtask

  // Reset mid-burst on stream 2, with stream 1 becoming valid meanwhile.
  task automatic reset_test();
    exp_t e;
    load(2, 8);
    for (int j = 0; j < N_PRE; j++) begin
      e.dat = src[2][j];
      e.sel = 2;
      e.cyc = -1;
      sb.push_back(e);
    end
    drive_cycle(0, 1'b1, 1'b0);
    drive_cycle(1, 1'b1, 1'b0);
    drive_cycle(2, 1'b1, 1'b0);
    load(1, 3);
    drive_cycle(3, 1'b1, 1'b1);
    model_ptr = 0;
    reset_chk = 1'b1;
    run_phase("after_reset", 0);
    reset_chk = 1'b0;
  endtask

  // MAXBURST=0 instance: 100 back-to-back words from stream 0, one grant.
  task automatic unlimited_test();
    int widx = 0;
    int nout = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      z_reset = 1'b0;
      z_i_val = {1'b0, (widx < 100)};
      z_i_dat = {8'h00, 8'(widx)};
      #4;
      if (z_o_val && z_o_rdy) begin
        check("unl_dat", z_o_dat, nout[7:0]);
        check("unl_cyc", c, nout + 1 + LAT);
        nout++;
      end
      if (z_i_val[0] && z_i_rdy[0]) widx++;
    end
    check("unl_count", nout, 100);
  endtask

  // Monitor: pops the scoreboard on every outbound transfer.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      check("i_rdy_only_granted", i_rdy & ~(4'b0001 << o_sel), 0);
      if (o_val === 1'b1 && o_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h, expected no word", o_dat);
        end else begin
          mon_e = sb.pop_front();
          check("out_dat", o_dat, mon_e.dat);
`ifndef DS_RR_ARBITER_OREG_EN
          check("out_sel", o_sel, mon_e.sel);
`endif
          if (mon_e.cyc >= 0) check("out_cyc", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    z_reset = 1'b1;
    o_rdy   = 1'b1;
    z_o_rdy = 1'b1;
    i_val   = '1;
    i_dat   = '0;
    z_i_val = '0;
    z_i_dat = '0;
    for (int k = 0; k < N; k++) seq[k] = 0;
    repeat (3) @(negedge clk);
    #4;
    check("reset_o_val", o_val, 0);
    check("reset_i_rdy", i_rdy, 0);
    check("reset_o_sel", o_sel, 0);
    drive_cycle(0, 1'b1, 1'b0);
    drive_cycle(1, 1'b1, 1'b0);

    load(0, 8); load(1, 4); load(2, 4); load(3, 4);
    run_phase("all_valid", 0);

    load(2, 10);
    run_phase("only_s2", 0);

    load(3, 2); load(0, 5);
    run_phase("s3_drop", 0);

    load(1, 4); load(2, 3);
    run_phase("stall_s1", 2);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) load(k, $urandom_range(0, 12));
      run_phase("random", r % 2);
    end

    reset_test();

    unlimited_test();

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
